// File: rtl/ram_master.sv
// ram_master: initiator for a 32x8 single-port RAM with combinational read data.
// It serves single-word read/write requests over a req/ready/ack handshake.
// It also performs a block fill that writes one value to every RAM address.
// All outputs come straight from registers.
module ram_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              fill_start_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FILL   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic                r_fill_pend;
  logic [DATA_W-1:0]   r_fill_data;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ready;
  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_fill_busy;
  logic                r_fill_done;
  logic                r_ram_wen;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;

  // A fill deferred behind a request uses the value captured with it;
  // a fill started during the access cycle itself uses the live input.
  logic [DATA_W-1:0]   w_fill_val;
  assign w_fill_val = r_fill_pend ? r_fill_data : fill_data_i;

  // Controller: request handshake, one-cycle RAM access, and the fill sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_fill_pend <= 1'b0;
      r_fill_data <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_fill_busy <= 1'b0;
      r_fill_done <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
    end else begin
      r_ack       <= 1'b0;
      r_fill_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i && r_ready) begin
            // The request wins over a simultaneous fill start; the fill is deferred.
            r_ram_addr <= addr_i;
            r_ram_wen  <= we_i;
            r_ram_din  <= wdata_i;
            r_ready    <= 1'b0;
            r_state    <= ST_ACCESS;
            if (fill_start_i) begin
              r_fill_pend <= 1'b1;
              r_fill_data <= fill_data_i;
            end
          end else if (fill_start_i) begin
            r_fill_data <= fill_data_i;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_ram_wen   <= 1'b1;
            r_ram_din   <= fill_data_i;
            r_fill_busy <= 1'b1;
            r_ready     <= 1'b0;
            r_state     <= ST_FILL;
          end else begin
            r_ready <= 1'b1;
          end
        end

        ST_ACCESS: begin
          // The RAM commits a write on this edge; a read captures the combinational data-out.
          r_ack <= 1'b1;
          if (!r_ram_wen) begin
            r_rdata <= ram_dout_i;
          end
          if (r_fill_pend || fill_start_i) begin
            r_fill_pend <= 1'b1;
            r_fill_data <= w_fill_val;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_ram_wen   <= 1'b1;
            r_ram_din   <= w_fill_val;
            r_fill_busy <= 1'b1;
            r_state     <= ST_FILL;
          end else begin
            r_ram_wen <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        ST_FILL: begin
          if (r_cnt == LAST_ADDR) begin
            // The last address is written on this edge; the sweep stops without wrapping.
            r_ram_wen   <= 1'b0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b1;
            r_fill_pend <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_ram_addr <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign ack_o       = r_ack;
  assign rdata_o     = r_rdata;
  assign fill_busy_o = r_fill_busy;
  assign fill_done_o = r_fill_done;
  assign ram_wen_o   = r_ram_wen;
  assign ram_addr_o  = r_ram_addr;
  assign ram_din_o   = r_ram_din;

endmodule

// File: tb/tb_ram_master.sv
// Testbench for ram_master. It contains a behavioural 32x8 RAM with combinational read.
// Expected values come from constant vectors and from a word-level memory model.
module tb_ram_master;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              ready_o;
  logic              ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic              fill_start_i;
  logic [DATA_W-1:0] fill_data_i;
  logic              fill_busy_o;
  logic              fill_done_o;
  logic              ram_wen_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_din_o;
  logic [DATA_W-1:0] ram_dout_i;

  always #5 clk = ~clk;

  ram_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .fill_start_i (fill_start_i),
    .fill_data_i  (fill_data_i),
    .fill_busy_o  (fill_busy_o),
    .fill_done_o  (fill_done_o),
    .ram_wen_o    (ram_wen_o),
    .ram_addr_o   (ram_addr_o),
    .ram_din_o    (ram_din_o),
    .ram_dout_i   (ram_dout_i)
  );

  // The behavioural RAM commits writes on the rising edge and reads combinationally.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_wen_o) ram[ram_addr_o] <= ram_din_o;
  assign ram_dout_i = ram[ram_addr_o];

  // The reference model tracks memory contents, last read data and last RAM address.
  logic [DATA_W-1:0] mem_model [DEPTH];
  logic [DATA_W-1:0] model_rdata;
  logic [ADDR_W-1:0] model_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [DATA_W-1:0] powerup_val(input int i);
    if (i == 0) return 8'h03;
    if (i == 1) return 8'h02;
    return 8'(i * 7 + 1);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = powerup_val(i);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a falling edge where ready_o should be high.
  // Returns at the falling edge of the ack cycle, so back-to-back calls run at peak rate.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd);
    chk("req_ready", 32'(ready_o), 32'd1);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    chk("acc_wen", 32'(ram_wen_o), 32'(we));
    chk("acc_addr", 32'(ram_addr_o), 32'(addr));
    if (we) chk("acc_din", 32'(ram_din_o), 32'(wdata));
    chk("acc_ack", 32'(ack_o), 32'd0);
    chk("acc_ready", 32'(ready_o), 32'd0);
    chk("acc_done", 32'(fill_done_o), 32'd0);
    @(negedge clk);
    chk("ack_pulse", 32'(ack_o), 32'd1);
    chk("ack_ready", 32'(ready_o), 32'd1);
    chk("ack_wen", 32'(ram_wen_o), 32'd0);
    chk("ack_rdata", 32'(rdata_o), 32'(exp_rd));
    if (we) mem_model[addr] = wdata;
    else model_rdata = exp_rd;
    model_addr = addr;
    $display("REQ we=%0d addr=%02h wdata=%02h rdata=%02h exp=%02h", we, addr, wdata, rdata_o, exp_rd);
  endtask

  // Entered at the falling edge of the first fill cycle.
  // Returns at the falling edge of the fill_done cycle.
  task automatic check_sweep(input logic [DATA_W-1:0] val, input bit first_ack);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_wen", 32'(ram_wen_o), 32'd1);
      chk("fill_addr", 32'(ram_addr_o), 32'(i));
      chk("fill_din", 32'(ram_din_o), 32'(val));
      chk("fill_busy", 32'(fill_busy_o), 32'd1);
      chk("fill_ready", 32'(ready_o), 32'd0);
      chk("fill_done_early", 32'(fill_done_o), 32'd0);
      chk("fill_ack", 32'(ack_o), 32'((i == 0) && first_ack));
      // A fill start during the sweep must be ignored.
      if (i == 5) begin fill_start_i = 1'b1; fill_data_i = 8'h11; end
      if (i == 6) begin fill_start_i = 1'b0; fill_data_i = 8'h00; end
      @(negedge clk);
    end
    chk("fill_done", 32'(fill_done_o), 32'd1);
    chk("done_busy", 32'(fill_busy_o), 32'd0);
    chk("done_wen", 32'(ram_wen_o), 32'd0);
    chk("done_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) mem_model[i] = val;
    model_addr = ADDR_W'(DEPTH - 1);
    $display("FILL data=%02h done=%0d", val, fill_done_o);
  endtask

  task automatic do_fill(input logic [DATA_W-1:0] val);
    fill_start_i = 1'b1; fill_data_i = val;
    @(negedge clk);
    fill_start_i = 1'b0; fill_data_i = 8'h00;
    check_sweep(val, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              w;

    vecs[0] = '{we: 1'b0, addr: 5'h00, wdata: 8'h00, exp_rd: 8'h03};
    vecs[1] = '{we: 1'b0, addr: 5'h01, wdata: 8'h00, exp_rd: 8'h02};
    vecs[2] = '{we: 1'b1, addr: 5'h1F, wdata: 8'hA5, exp_rd: 8'h02};
    vecs[3] = '{we: 1'b0, addr: 5'h1F, wdata: 8'h00, exp_rd: 8'hA5};

    for (int i = 0; i < DEPTH; i++) mem_model[i] = powerup_val(i);
    model_rdata = '0;
    model_addr  = '0;

    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    fill_start_i = 1'b0; fill_data_i = '0;

    // Reset: check outputs during two reset cycles, then check ready after release.
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_rdata", 32'(rdata_o), 32'd0);
    chk("rst_busy", 32'(fill_busy_o), 32'd0);
    chk("rst_done", 32'(fill_done_o), 32'd0);
    chk("rst_wen", 32'(ram_wen_o), 32'd0);
    chk("rst_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_din", 32'(ram_din_o), 32'd0);
    @(negedge clk);
    chk("rst_ready2", 32'(ready_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    // Apply directed vectors: power-up reads, then write and read back 0x1F.
    for (int i = 0; i < 4; i++) do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Start a request and a fill in the same cycle; the read must win.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 5'h01;
    fill_start_i = 1'b1; fill_data_i = 8'h77;
    @(negedge clk);
    req_i = 1'b0; fill_start_i = 1'b0; fill_data_i = 8'h00; addr_i = '0;
    chk("both_acc_wen", 32'(ram_wen_o), 32'd0);
    chk("both_acc_addr", 32'(ram_addr_o), 32'h01);
    chk("both_acc_busy", 32'(fill_busy_o), 32'd0);
    chk("both_acc_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    chk("both_rdata", 32'(rdata_o), 32'h02);
    model_rdata = 8'h02;
    $display("REQ we=0 addr=01 with fill_start, rdata=%02h", rdata_o);
    check_sweep(8'h77, 1'b1);

    // Fill with 0x5A, then read a few addresses back.
    @(negedge clk);
    do_fill(8'h5A);
    do_req(1'b0, 5'd0,  8'h00, 8'h5A);
    do_req(1'b0, 5'd17, 8'h00, 8'h5A);
    do_req(1'b0, 5'd31, 8'h00, 8'h5A);

    // Reset during a fill of 0xFF while address 10 is being written.
    @(negedge clk);
    fill_start_i = 1'b1; fill_data_i = 8'hFF;
    @(negedge clk);
    fill_start_i = 1'b0; fill_data_i = 8'h00;
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("midrst_addr", 32'(ram_addr_o), 32'd10);
    chk("midrst_wen", 32'(ram_wen_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_wen_off", 32'(ram_wen_o), 32'd0);
    chk("midrst_done", 32'(fill_done_o), 32'd0);
    chk("midrst_busy", 32'(fill_busy_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_done2", 32'(fill_done_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i <= 10; i++) mem_model[i] = 8'hFF;
    model_rdata = '0;
    model_addr  = '0;
    do_req(1'b0, 5'd10, 8'h00, 8'hFF);
    do_req(1'b0, 5'd11, 8'h00, mem_model[11]);

    // Random traffic checked against the memory model, with random idle gaps and occasional fills.
    for (int k = 0; k < 60; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        chk("idle_wen", 32'(ram_wen_o), 32'd0);
        chk("idle_ack", 32'(ack_o), 32'd0);
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_addr_hold", 32'(ram_addr_o), 32'(model_addr));
      end
      if ($urandom_range(0, 19) == 0) begin
        d = 8'($urandom);
        do_fill(d);
      end else begin
        w = 1'($urandom);
        a = 5'($urandom);
        d = 8'($urandom);
        do_req(w, a, d, w ? model_rdata : mem_model[a]);
      end
    end

    // The RAM contents must match the model; stray writes would show up here.
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(ram[i]), 32'(mem_model[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
